// File: rtl/bitseq_pkg.sv
// bitseq_pkg: shared types and constants for the 1-bit sequence recorder.
//   state_t    : recorder FSM states
//   TRIG_*     : edge-trigger mode codes (used when BITSEQ_REC_EDGE_TRIG_EN is defined)
//   DEFAULT_AW : default address width (depth = 2**AW bits)
//   edge_hit() : edge qualifier for the ARM state
package bitseq_pkg;
    localparam int DEFAULT_AW = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_ARM     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] TRIG_NONE = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;
    localparam logic [1:0] TRIG_ANY  = 2'd3;

    // TRIG_NONE always qualifies so ARM is crossed in a single clock.
    function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
        return mode == TRIG_NONE ? 1'b1 :
               mode == TRIG_RISE ? (cur & ~prev) :
               mode == TRIG_FALL ? (~cur & prev) : (cur ^ prev);
    endfunction
endpackage

// File: rtl/bitseq_sync2.sv
// bitseq_sync2: two-flop synchronizer, both stages cleared by async reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output, 2 clocks behind d_i
module bitseq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/bitseq_recorder.sv
// bitseq_recorder: single-channel 1-bit sequence capture into a 2**AW-bit LUTRAM.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start_trig            : arm pulse, honoured in IDLE or DONE only
//   stop                  : synchronous abort back to IDLE
//   len                   : bits to capture (0..2**AW, larger values clamp)
//   rate_div              : sample period = rate_div+1 clocks
//   phase_off             : clocks of delay before capture
//   trig_mode             : edge trigger select (only with BITSEQ_REC_EDGE_TRIG_EN)
//   io_in                 : asynchronous channel pin
//   rd_addr / rd_bit      : combinational host read port
//   capturing, done       : registered state decodes
//   cap_cnt               : bits written in the current/last capture
// Optional feature macro: BITSEQ_REC_EDGE_TRIG_EN adds the ARM state and trig_mode.
module bitseq_recorder
    import bitseq_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_trig,
    input  logic          stop,
    input  logic [AW:0]   len,
    input  logic [31:0]   rate_div,
    input  logic [31:0]   phase_off,
`ifdef BITSEQ_REC_EDGE_TRIG_EN
    input  logic [1:0]    trig_mode,
`endif
    input  logic          io_in,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_bit,
    output logic          capturing,
    output logic          done,
    output logic [AW:0]   cap_cnt
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic          s_in;
    state_t        state_q, state_d;
    logic [31:0]   phs_q, div_q;
    logic [AW:0]   wr_q, cap_q, len_c;
    logic          capturing_q, done_q;
    logic          restart, div_hit, we, last;
    logic          mem [2**AW];

    bitseq_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d_i(io_in), .q_o(s_in));

`ifdef BITSEQ_REC_EDGE_TRIG_EN
    logic prev_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= s_in;
    end
`endif

    always_comb begin
        len_c   = len > DEPTH ? DEPTH : len;
        restart = start_trig && (state_q == ST_IDLE || state_q == ST_DONE);
        div_hit = div_q == rate_div;
        we      = !stop && state_q == ST_CAPTURE && div_hit;
        last    = wr_q == len_c - (AW+1)'(1);
        state_d = state_q;
        if (restart)
            state_d = len == '0 ? ST_DONE : ST_DELAY;
        else if (stop)
            state_d = ST_IDLE;
        else if (state_q == ST_DELAY && phs_q == '0)
`ifdef BITSEQ_REC_EDGE_TRIG_EN
            state_d = ST_ARM;
        else if (state_q == ST_ARM && edge_hit(trig_mode, s_in, prev_q))
`endif
            state_d = ST_CAPTURE;
        else if (we && last)
            state_d = ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phs_q       <= '0;
            div_q       <= '0;
            wr_q        <= '0;
            cap_q       <= '0;
            capturing_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            capturing_q <= state_d inside {ST_DELAY, ST_ARM, ST_CAPTURE};
            done_q      <= state_d == ST_DONE;
            if (restart) begin
                phs_q <= phase_off;
                div_q <= '0;
                wr_q  <= '0;
                cap_q <= '0;
            end else if (!stop) begin
                if (state_q == ST_DELAY && phs_q != '0)
                    phs_q <= phs_q - 32'd1;
                // Preloading div_cnt makes the first write land on the clock after the edge.
                if (state_q == ST_ARM)
                    div_q <= rate_div;
                if (state_q == ST_CAPTURE) begin
                    div_q <= div_hit ? '0 : div_q + 32'd1;
                    if (div_hit) begin
                        wr_q  <= wr_q + (AW+1)'(1);
                        cap_q <= cap_q + (AW+1)'(1);
                    end
                end
            end
        end
    end

    // Kept free of reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) mem[wr_q[AW-1:0]] <= s_in;
    end

    assign rd_bit    = mem[rd_addr];
    assign capturing = capturing_q;
    assign done      = done_q;
    assign cap_cnt   = cap_q;
endmodule

// File: tb/tb_bitseq_recorder.sv
// tb_bitseq_recorder: directed bench with a timing-based reference model for bitseq_recorder.
module tb_bitseq_recorder;
    localparam int AW = 4;
`ifdef BITSEQ_REC_EDGE_TRIG_EN
    localparam int LAT = 1;
    localparam int T2_FIRST = 8;
`else
    localparam int LAT = 0;
    localparam int T2_FIRST = 10;
`endif

    logic          clk = 0, rst_n = 0, start_trig = 0, stop = 0, io_in = 0;
    logic [AW:0]   len = '0;
    logic [31:0]   rate_div = '0, phase_off = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_bit, capturing, done;
    logic [AW:0]   cap_cnt;
`ifdef BITSEQ_REC_EDGE_TRIG_EN
    logic [1:0]    trig_mode = 2'd0;
`endif

    int errors = 0, checks = 0, n = 0;
    logic [7:0]  pat8  = 8'b10110010;
    logic [15:0] pat16 = 16'b1100_1010_0111_0001;

    always #5 clk = ~clk;

    bitseq_recorder #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_trig(start_trig), .stop(stop),
        .len(len), .rate_div(rate_div), .phase_off(phase_off),
`ifdef BITSEQ_REC_EDGE_TRIG_EN
        .trig_mode(trig_mode),
`endif
        .io_in(io_in), .rd_addr(rd_addr), .rd_bit(rd_bit),
        .capturing(capturing), .done(done), .cap_cnt(cap_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, n);
        end
    endtask

    // Model: the k-th bit is written a fixed time after start and carries the pin value 2 clocks earlier.
    logic   io_at [0:16383];
    bit     m_act = 0, m_done = 0, model_en = 1;
    int     m_cnt = 0, m_left = 0;
    longint m_next = 0;
    logic   mm [0:15];
    bit     mv [0:15];

    always @(posedge clk) begin
        io_at[n] = io_in;
        if (!rst_n) begin
            m_act = 0; m_done = 0; m_cnt = 0;
        end else if (start_trig && !m_act) begin
            m_cnt = 0;
            if (len == 0) begin
                m_act = 0; m_done = 1;
            end else begin
                m_act = 1; m_done = 0;
                m_left = len > 16 ? 16 : int'(len);
`ifdef BITSEQ_REC_EDGE_TRIG_EN
                m_next = n + longint'(phase_off) + 3;
`else
                m_next = n + longint'(phase_off) + longint'(rate_div) + 2;
`endif
            end
        end else if (stop) begin
            m_act = 0; m_done = 0;
        end else if (m_act && n == m_next) begin
            mm[m_cnt] = io_at[n-2];
            mv[m_cnt] = 1;
            m_cnt++;
            m_next += longint'(rate_div) + 1;
            if (m_cnt == m_left) begin
                m_act = 0; m_done = 1;
            end
        end
        n++;
    end

    always @(negedge clk) begin
        if (rst_n && model_en) begin
            chk("m_capturing", 32'(capturing), 32'(m_act));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_cap_cnt", 32'(cap_cnt), 32'(m_cnt));
            if (mv[rd_addr]) chk("m_rd_bit", 32'(rd_bit), 32'(mm[rd_addr]));
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 400 && done !== 1'b1; i++) tick(1);
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic rd(input string nm, input int a, input logic exp);
        rd_addr = AW'(a);
        #1;
        chk(nm, 32'(rd_bit), 32'(exp));
    endtask

    initial begin
        tick(3);
        chk("rst_capturing", 32'(capturing), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cap_cnt", 32'(cap_cnt), 0);
        rst_n = 1;
        tick(3);

        // 1: 8 bits at one bit per clock
        len = 8; rate_div = 0; phase_off = 0;
        start_trig = 1; io_in = pat8[7];
        tick(1 + LAT);
        start_trig = 0;
        for (int i = 1; i < 8; i++) begin
            io_in = pat8[7-i];
            tick(1);
        end
        wait_done("t1_done");
        chk("t1_cap_cnt", 32'(cap_cnt), 8);
        for (int i = 0; i < 8; i++) rd("t1_mem", i, pat8[7-i]);

        // 2: delayed start and divided rate
        io_in = 1; tick(3);
        rate_div = 3; phase_off = 5;
        start_trig = 1; tick(1); start_trig = 0;
        tick(T2_FIRST - 1);
        chk("t2_before_first", 32'(cap_cnt), 0);
        tick(1);
        chk("t2_first_write", 32'(cap_cnt), 1);
        tick(3);
        chk("t2_gap", 32'(cap_cnt), 1);
        tick(1);
        chk("t2_second_write", 32'(cap_cnt), 2);
        wait_done("t2_done");
        chk("t2_cap_cnt", 32'(cap_cnt), 8);

        // 3: full depth, no wrap; stop in DONE keeps the count
        len = 16; rate_div = 0; phase_off = 0;
        start_trig = 1; io_in = pat16[0];
        tick(1 + LAT);
        start_trig = 0;
        for (int i = 1; i < 16; i++) begin
            io_in = pat16[i];
            tick(1);
        end
        wait_done("t3_done");
        chk("t3_cap_cnt", 32'(cap_cnt), 16);
        for (int i = 0; i < 16; i++) rd("t3_mem", i, pat16[i]);
        stop = 1; tick(1); stop = 0;
        chk("t3_stop_done", 32'(done), 0);
        chk("t3_stop_cnt", 32'(cap_cnt), 16);

        // 4: abort after three samples
        io_in = 0; tick(3);
        len = 8; rate_div = 1;
        start_trig = 1; tick(1); start_trig = 0;
        tick(7);
        stop = 1; tick(1); stop = 0;
        chk("t4_capturing", 32'(capturing), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_cap_cnt", 32'(cap_cnt), 3);
        tick(4);
        chk("t4_cnt_held", 32'(cap_cnt), 3);
        for (int i = 0; i < 8; i++) rd("t4_mem", i, i < 3 ? 1'b0 : pat16[i]);

        // 5: ignored re-start, restart beats stop, zero length
        len = 8; rate_div = 0;
        start_trig = 1; tick(1); start_trig = 0;
        tick(3);
        start_trig = 1; tick(1); start_trig = 0;
        wait_done("t5_done");
        chk("t5_cap_cnt", 32'(cap_cnt), 8);
        start_trig = 1; stop = 1; tick(1); start_trig = 0; stop = 0;
        chk("t5_restart_cap", 32'(capturing), 1);
        chk("t5_restart_done", 32'(done), 0);
        chk("t5_restart_cnt", 32'(cap_cnt), 0);
        stop = 1; tick(1); stop = 0;
        chk("t5_stop_idle", 32'(capturing), 0);
        len = 0;
        start_trig = 1; tick(1); start_trig = 0;
        chk("t5_len0_done", 32'(done), 1);
        chk("t5_len0_cnt", 32'(cap_cnt), 0);
        chk("t5_len0_cap", 32'(capturing), 0);

`ifdef BITSEQ_REC_EDGE_TRIG_EN
        // 6: rising-edge trigger
        model_en = 0;
        io_in = 0; trig_mode = 2'd1; tick(3);
        len = 4; rate_div = 2; phase_off = 3;
        start_trig = 1; tick(1); start_trig = 0;
        tick(4 + 20);
        chk("t6_armed", 32'(capturing), 1);
        chk("t6_armed_cnt", 32'(cap_cnt), 0);
        io_in = 1;
        tick(3);
        chk("t6_pre_edge_write", 32'(cap_cnt), 0);
        tick(1);
        chk("t6_edge_write", 32'(cap_cnt), 1);
        rd("t6_mem0", 0, 1'b1);
        wait_done("t6_done");
        chk("t6_cap_cnt", 32'(cap_cnt), 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
